// File: rtl/ps2_key_controller_if.sv
// Bundle of the scan-code input strobe, the player key vectors and the
// press/release event stream between the PS/2 receiver and the game logic.
interface ps2_key_controller_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [4:0] p1_keys;
  logic [4:0] p2_keys;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_player;
  logic [2:0] evt_action;
  logic       evt_press;
  logic       overflow;

  modport master (
    output byte_valid, byte_data, evt_ready,
    input  p1_keys, p2_keys, evt_valid, evt_player, evt_action, evt_press, overflow
  );

  modport slave (
    input  byte_valid, byte_data, evt_ready,
    output p1_keys, p2_keys, evt_valid, evt_player, evt_action, evt_press, overflow
  );
endinterface

// File: rtl/ps2_key_controller.sv
// Turns PS/2 scan-code bytes into two-player key state and a queue of
// press/release events, handling the E0/F0 prefixes and an idle timeout.
module ps2_key_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset,
  ps2_key_controller_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ADDR_W = PTR_W - 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              w_decode;
  logic              w_isExt;
  logic              w_isBrk;
  logic              w_tmoHit;
  logic [CNT_W-1:0]  r_tmoCnt;

  logic              w_mapped;
  logic              w_player;
  logic [2:0]        w_action;
  logic [4:0]        w_mask;
  logic              w_curBit;
  logic              w_press;
  logic              w_change;
  logic [4:0]        r_p1Keys;
  logic [4:0]        r_p2Keys;

  logic [4:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_pushOk;
  logic              w_drop;
  logic [4:0]        w_entry;
  logic [4:0]        w_head;
  logic [4:0]        w_shown;
  logic [4:0]        r_lastHead;
  logic              r_overflow;

  assign w_tmoHit = (r_state != S_IDLE) && (r_tmoCnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_decode    = 1'b0;
    w_isExt     = 1'b0;
    w_isBrk     = 1'b0;
    if (bus.byte_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.byte_data == CODE_EXT)      w_nextState = S_EXT;
          else if (bus.byte_data == CODE_BRK) w_nextState = S_BRK;
          else                                w_decode    = 1'b1;
        end
        S_EXT: begin
          if (bus.byte_data == CODE_BRK)      w_nextState = S_EXT_BRK;
          else if (bus.byte_data != CODE_EXT) begin
            w_decode    = 1'b1;
            w_isExt     = 1'b1;
            w_nextState = S_IDLE;
          end
        end
        S_BRK: begin
          if (bus.byte_data == CODE_EXT)      w_nextState = S_EXT_BRK;
          else if (bus.byte_data != CODE_BRK) begin
            w_decode    = 1'b1;
            w_isBrk     = 1'b1;
            w_nextState = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (bus.byte_data != CODE_EXT && bus.byte_data != CODE_BRK) begin
            w_decode    = 1'b1;
            w_isExt     = 1'b1;
            w_isBrk     = 1'b1;
            w_nextState = S_IDLE;
          end
        end
        default: w_nextState = S_IDLE;
      endcase
    end else if (w_tmoHit) begin
      w_nextState = S_IDLE;
    end
  end

  // An incoming byte always restarts the idle window, even on the expiry cycle.
  always_ff @(posedge clk) begin
    if (reset)
      r_tmoCnt <= '0;
    else if (bus.byte_valid || r_state == S_IDLE || w_tmoHit)
      r_tmoCnt <= '0;
    else
      r_tmoCnt <= r_tmoCnt + 1'b1;
  end

  always_comb begin
    w_mapped = 1'b0;
    w_player = w_isExt;
    w_action = 3'd0;
    if (!w_isExt) begin
      unique case (bus.byte_data)
        8'h1D:   begin w_mapped = 1'b1; w_action = 3'd0; end
        8'h1B:   begin w_mapped = 1'b1; w_action = 3'd1; end
        8'h1C:   begin w_mapped = 1'b1; w_action = 3'd2; end
        8'h23:   begin w_mapped = 1'b1; w_action = 3'd3; end
        8'h29:   begin w_mapped = 1'b1; w_action = 3'd4; end
        default: w_mapped = 1'b0;
      endcase
    end else begin
      unique case (bus.byte_data)
        8'h75:   begin w_mapped = 1'b1; w_action = 3'd0; end
        8'h72:   begin w_mapped = 1'b1; w_action = 3'd1; end
        8'h6B:   begin w_mapped = 1'b1; w_action = 3'd2; end
        8'h74:   begin w_mapped = 1'b1; w_action = 3'd3; end
        8'h14:   begin w_mapped = 1'b1; w_action = 3'd4; end
        default: w_mapped = 1'b0;
      endcase
    end
  end

  // Only real state changes become events; typematic repeats are filtered here.
  assign w_mask   = 5'b00001 << w_action;
  assign w_curBit = |((w_player ? r_p2Keys : r_p1Keys) & w_mask);
  assign w_press  = ~w_isBrk;
  assign w_change = w_decode && w_mapped && (w_curBit != w_press);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1Keys <= '0;
      r_p2Keys <= '0;
    end else if (w_change) begin
      if (w_player) r_p2Keys <= w_press ? (r_p2Keys | w_mask) : (r_p2Keys & ~w_mask);
      else          r_p1Keys <= w_press ? (r_p1Keys | w_mask) : (r_p1Keys & ~w_mask);
    end
  end

  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]) &&
                    (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]);
  assign w_pop    = !w_empty && bus.evt_ready;
  assign w_pushOk = w_change && (!w_full || w_pop);
  assign w_drop   = w_change && w_full && !w_pop;
  assign w_entry  = {w_player, w_action, w_press};
  assign w_head   = r_mem[r_rdPtr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr[ADDR_W-1:0]] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
      r_lastHead <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + 1'b1;
        r_lastHead <= w_head;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // When drained, the outputs keep showing the entry that was popped last.
  assign w_shown        = w_empty ? r_lastHead : w_head;
  assign bus.evt_valid  = !w_empty;
  assign bus.evt_player = w_shown[4];
  assign bus.evt_action = w_shown[3:1];
  assign bus.evt_press  = w_shown[0];
  assign bus.overflow   = r_overflow;
  assign bus.p1_keys    = r_p1Keys;
  assign bus.p2_keys    = r_p2Keys;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed and random scan-code stimulus for ps2_key_controller, compared
// every cycle against a prefix-flag / event-queue reference model.
module tb_ps2_key_controller;

  localparam int DEPTH = 8;
  localparam int TMO   = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_key_controller_if bus ();

  ps2_key_controller #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit [4:0]   mKeys [2];
  logic [4:0] mQ [$];
  logic [4:0] mLast;
  bit         mOvf;
  bit         mExt;
  bit         mBrk;
  int         cyc;
  int         lastByteCyc;

  logic [7:0] pool [17] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B,
                            8'h74, 8'h14, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'h2B, 8'h77};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int mapCode(input bit ext, input logic [7:0] code);
    int a;
    a = -1;
    if (!ext) begin
      case (code)
        8'h1D: a = 0;
        8'h1B: a = 1;
        8'h1C: a = 2;
        8'h23: a = 3;
        8'h29: a = 4;
        default: a = -1;
      endcase
    end else begin
      case (code)
        8'h75: a = 0;
        8'h72: a = 1;
        8'h6B: a = 2;
        8'h74: a = 3;
        8'h14: a = 4;
        default: a = -1;
      endcase
    end
    return a;
  endfunction

  task automatic modelReset();
    mKeys[0] = '0;
    mKeys[1] = '0;
    mQ.delete();
    mLast = '0;
    mOvf = 1'b0;
    mExt = 1'b0;
    mBrk = 1'b0;
    lastByteCyc = cyc;
  endtask

  // A prefix is forgotten if the next byte comes more than TMO edges later.
  task automatic modelStep(input bit bv, input logic [7:0] d, input bit rdy);
    bit         pop;
    bit         push;
    bit         p;
    bit         press;
    int         a;
    logic [4:0] ev;
    cyc++;
    pop  = (mQ.size() > 0) && rdy;
    push = 1'b0;
    ev   = '0;
    if (bv) begin
      if ((mExt || mBrk) && (cyc - lastByteCyc > TMO)) begin
        mExt = 1'b0;
        mBrk = 1'b0;
      end
      lastByteCyc = cyc;
      if (d == 8'hE0) mExt = 1'b1;
      else if (d == 8'hF0) mBrk = 1'b1;
      else begin
        a     = mapCode(mExt, d);
        p     = mExt;
        press = !mBrk;
        mExt  = 1'b0;
        mBrk  = 1'b0;
        if (a >= 0 && mKeys[p][a] != press) begin
          mKeys[p][a] = press;
          push = 1'b1;
          ev   = {p, a[2:0], press};
        end
      end
    end
    if (pop) mLast = mQ.pop_front();
    if (push) begin
      if (mQ.size() < DEPTH) mQ.push_back(ev);
      else mOvf = 1'b1;
    end
  endtask

  task automatic compareAll();
    logic [4:0] head;
    head = (mQ.size() > 0) ? mQ[0] : mLast;
    checkOutput("p1_keys", bus.p1_keys, mKeys[0]);
    checkOutput("p2_keys", bus.p2_keys, mKeys[1]);
    checkOutput("evt_valid", bus.evt_valid, (mQ.size() > 0));
    checkOutput("evt_player", bus.evt_player, head[4]);
    checkOutput("evt_action", bus.evt_action, head[3:1]);
    checkOutput("evt_press", bus.evt_press, head[0]);
    checkOutput("overflow", bus.overflow, mOvf);
  endtask

  task automatic applyStimulus(input bit bv, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    bus.byte_valid = bv;
    bus.byte_data  = d;
    bus.evt_ready  = rdy;
    modelStep(bv, d, rdy);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.evt_ready  = 1'b0;
    cyc++;
    modelReset();
    @(posedge clk);
    #1;
    compareAll();
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, input bit rdy);
    applyStimulus(1'b1, d, rdy);
    applyStimulus(1'b0, 8'h00, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy);
  endtask

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.evt_ready  = 1'b0;
    cyc            = 0;
    modelReset();
    applyReset();
    applyReset();

    // Typematic repeat yields a single press event.
    sendByte(8'h1D, 1'b0);
    sendByte(8'h1D, 1'b0);
    sendByte(8'h1D, 1'b0);
    idle(3, 1'b1);

    // Extended press then extended release, drained in order.
    sendByte(8'hE0, 1'b0);
    sendByte(8'h75, 1'b0);
    sendByte(8'hE0, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h75, 1'b0);
    idle(4, 1'b1);

    // Prefix abandoned after the idle window, then kept at the exact boundary.
    applyStimulus(1'b1, 8'hE0, 1'b0);
    idle(TMO, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    idle(TMO - 1, 1'b0);
    applyStimulus(1'b1, 8'h75, 1'b0);
    idle(4, 1'b1);

    // Nine changes overflow the queue; the tenth lands with a same-cycle pop.
    applyReset();
    sendByte(8'h1D, 1'b0);
    sendByte(8'h1B, 1'b0);
    sendByte(8'h1C, 1'b0);
    sendByte(8'h23, 1'b0);
    sendByte(8'h29, 1'b0);
    sendByte(8'hF0, 1'b0); sendByte(8'h1D, 1'b0);
    sendByte(8'hF0, 1'b0); sendByte(8'h1B, 1'b0);
    sendByte(8'hF0, 1'b0); sendByte(8'h1C, 1'b0);
    sendByte(8'hF0, 1'b0); sendByte(8'h23, 1'b0);
    sendByte(8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h29, 1'b1);
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Unmapped codes and Pause leave everything untouched.
    applyReset();
    sendByte(8'h14, 1'b1);
    sendByte(8'hE1, 1'b1);
    sendByte(8'h14, 1'b1);
    sendByte(8'h77, 1'b1);
    sendByte(8'h2B, 1'b1);
    sendByte(8'h1C, 1'b0);
    idle(2, 1'b1);

    // Reset between F0 and the key byte discards the break prefix.
    applyReset();
    sendByte(8'h23, 1'b1);
    sendByte(8'hF0, 1'b0);
    applyReset();
    sendByte(8'h23, 1'b0);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      bit         bv;
      bit         rdy;
      logic [7:0] d;
      bv  = ($urandom_range(0, 2) == 0);
      d   = pool[$urandom_range(0, 16)];
      rdy = ($urandom_range(0, 3) != 0) && (((i / 200) % 3) != 1);
      if ($urandom_range(0, 700) == 0) applyReset();
      else if ($urandom_range(0, 80) == 0) idle($urandom_range(TMO - 2, TMO + 2), rdy);
      else applyStimulus(bv, d, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
